// File: rtl/ser_link_pkg.sv
// Shared definitions for the serial parameter link.
// Both the serializer and the deserializer import this package so that
// the sync pattern, word geometry and state names agree at both ends.
package ser_link_pkg;

   localparam int WORD_W_DEF    = 35;
   localparam int NUM_WORDS_DEF = 12;

   // Sync test pattern sent ahead of every payload
   localparam logic [WORD_W_DEF-1:0] TP_DEF = 35'h5_A5A5_A5A5;

   typedef enum logic [1:0] {
      IDLE,
      SYNC,
      DATA,
      GAP
   } ser_state_t;

   // Bits on the wire per frame: the sync word plus every payload word
   function automatic int frame_bits(input int num_words, input int word_w);
      return (1 + num_words) * word_w;
   endfunction

endpackage

// File: rtl/ser_bit_timer.sv
// Serial bit timer: divides clk_in into bit periods of CLKDIV cycles.
// The serial clock is low for the first half of a bit and high for the
// second half, so the receiver's rising-edge sample lands mid-bit.
module ser_bit_timer
#(
   parameter int CLKDIV = 8
)(
   input  logic clk_in,
   input  logic rst_in,
   input  logic run,
   input  logic clk_en_next,
   output logic ser_clk,
   output logic bit_start,
   output logic bit_end
);

   localparam int PW = $clog2(CLKDIV);
   localparam logic [PW-1:0] LAST_PHASE = PW'(CLKDIV - 1);
   localparam logic [PW-1:0] HALF_PHASE = PW'(CLKDIV / 2);

   logic [PW-1:0] phase;
   logic [PW-1:0] phase_next;

   // Phase advances while a frame is active and wraps at the terminal count
   always_comb begin
      phase_next = '0;
      if (run && (phase != LAST_PHASE)) begin
         phase_next = phase + 1'b1;
      end
   end

   // Register the phase and the serial clock level for the coming cycle
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         phase   <= '0;
         ser_clk <= 1'b0;
      end else begin
         phase   <= phase_next;
         ser_clk <= clk_en_next && (phase_next >= HALF_PHASE);
      end
   end

   assign bit_start = run && (phase == '0);
   assign bit_end   = run && (phase == LAST_PHASE);

endmodule

// File: rtl/param_serializer.sv
// Transmit end of the servo parameter link. A frame is the sync pattern
// followed by NUM_WORDS signed coefficient words, each sent MSB first,
// then a few idle bit periods before done is pulsed. Payload is captured
// into a shadow register at start so later input changes cannot tear it.
module param_serializer
   import ser_link_pkg::*;
#(
   parameter int                NUM_WORDS = NUM_WORDS_DEF,
   parameter int                WORD_W    = WORD_W_DEF,
   parameter int                CLKDIV    = 8,
   parameter logic [WORD_W-1:0] TP        = TP_DEF,
   parameter int                GAP_BITS  = 4
)(
   input  logic                        clk_in,
   input  logic                        rst_in,
   input  logic                        start_in,
   input  logic [NUM_WORDS*WORD_W-1:0] words_in,
   output logic                        busy_out,
   output logic                        done_out,
   output logic                        ser_clk_out,
   output logic                        ser_trig_out,
   output logic                        ser_data_out
);

   localparam int BCW = $clog2(WORD_W);
   localparam int WCW = $clog2(NUM_WORDS + 1);
   localparam logic [BCW-1:0] LAST_BIT  = BCW'(WORD_W - 1);
   localparam logic [BCW-1:0] GAP_END   = BCW'(GAP_BITS);
   localparam logic [WCW-1:0] LAST_WORD = WCW'(NUM_WORDS);

   ser_state_t        state;
   ser_state_t        state_next;
   logic [WORD_W-1:0] shadow      [NUM_WORDS];
   logic [WORD_W-1:0] shadow_next [NUM_WORDS];
   logic [WORD_W-1:0] shift_reg;
   logic [WORD_W-1:0] shift_next;
   logic [BCW-1:0]    bit_cnt;
   logic [BCW-1:0]    bit_next;
   logic [WCW-1:0]    word_cnt;
   logic [WCW-1:0]    word_next;
   logic              busy_next;
   logic              trig_next;
   logic              done_next;
   logic              bit_start;
   logic              bit_end;

   ser_bit_timer #(
      .CLKDIV(CLKDIV)
   ) u_timer (
      .clk_in     (clk_in),
      .rst_in     (rst_in),
      .run        (state != IDLE),
      .clk_en_next(trig_next),
      .ser_clk    (ser_clk_out),
      .bit_start  (bit_start),
      .bit_end    (bit_end)
   );

   // The line bit is the MSB of the shift register; it is cleared on the
   // way into the gap, so idle and gap periods stay low without extra gating
   assign ser_data_out = shift_reg[WORD_W-1];

   // Next-state logic: sequencing of sync word, payload words and gap.
   // word_cnt counts frame words, 0 being the sync pattern, so during the
   // payload it also indexes the next shadow word to load.
   always_comb begin
      state_next  = state;
      shadow_next = shadow;
      shift_next  = shift_reg;
      bit_next    = bit_cnt;
      word_next   = word_cnt;
      done_next   = 1'b0;
      case (state)
         IDLE: begin
            if (start_in) begin
               for (int k = 0; k < NUM_WORDS; k++) begin
                  shadow_next[k] = words_in[k*WORD_W +: WORD_W];
               end
               shift_next = TP;
               bit_next   = '0;
               word_next  = '0;
               state_next = SYNC;
            end
         end
         SYNC, DATA: begin
            if (bit_end) begin
               if (bit_cnt == LAST_BIT) begin
                  bit_next = '0;
                  if ((state == DATA) && (word_cnt == LAST_WORD)) begin
                     word_next  = '0;
                     shift_next = '0;
                     state_next = GAP;
                  end else begin
                     shift_next = shadow[word_cnt];
                     word_next  = word_cnt + 1'b1;
                     state_next = DATA;
                  end
               end else begin
                  bit_next   = bit_cnt + 1'b1;
                  shift_next = {shift_reg[WORD_W-2:0], 1'b0};
               end
            end
         end
         GAP: begin
            if (bit_start) begin
               bit_next = bit_cnt + 1'b1;
            end
            if (bit_end && (bit_cnt == GAP_END)) begin
               bit_next   = '0;
               state_next = IDLE;
               done_next  = 1'b1;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
      busy_next = (state_next != IDLE);
      trig_next = (state_next == SYNC) || (state_next == DATA);
   end

   // State, datapath and registered status outputs
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state        <= IDLE;
         shift_reg    <= '0;
         bit_cnt      <= '0;
         word_cnt     <= '0;
         busy_out     <= 1'b0;
         done_out     <= 1'b0;
         ser_trig_out <= 1'b0;
         for (int k = 0; k < NUM_WORDS; k++) begin
            shadow[k] <= '0;
         end
      end else begin
         state        <= state_next;
         shift_reg    <= shift_next;
         bit_cnt      <= bit_next;
         word_cnt     <= word_next;
         busy_out     <= busy_next;
         done_out     <= done_next;
         ser_trig_out <= trig_next;
         for (int k = 0; k < NUM_WORDS; k++) begin
            shadow[k] <= shadow_next[k];
         end
      end
   end

endmodule
